// File: rtl/mac_feeder_if.sv
// Handshake and operand bus between mac_feeder, its pair source, the mac datapath
// and the psum sink. The slave modport is the feeder's view.
interface mac_feeder_if #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [bw-1:0]        in_a;
    logic [bw-1:0]        in_b;
    logic [4*bw-1:0]      mac_a;
    logic [4*bw-1:0]      mac_b;
    logic [psum_bw-1:0]   mac_c;
    logic [psum_bw-1:0]   mac_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [psum_bw-1:0]   out_psum;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, mac_out, out_ready,
        input  in_ready, mac_a, mac_b, mac_c, out_valid, out_psum, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, mac_out, out_ready,
        output in_ready, mac_a, mac_b, mac_c, out_valid, out_psum, busy
    );
endinterface

// File: rtl/mac_feeder.sv
// Packs serial (activation, weight) pairs into 4-lane mac operands and accumulates GROUPS
// issues into one psum. Optional early flush port enabled by MAC_FEEDER_FLUSH_EN.
module mac_feeder #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int GROUPS  = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef MAC_FEEDER_FLUSH_EN
    input  logic flush,
`endif
    mac_feeder_if.slave bus
);
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);

    typedef enum logic [1:0] {FILL, ISSUE, OUT} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          lane_cnt_reg, lane_cnt_next;
    logic [GW-1:0]       grp_cnt_reg, grp_cnt_next;
    logic [psum_bw-1:0]  acc_reg, acc_next;
    logic [3:0]          lane_we;
    logic                lane_zero;
    logic                last_issue;
    logic                in_ready;
    logic                out_valid;
    logic [4*bw-1:0]     mac_a;
    logic [4*bw-1:0]     mac_b;
`ifdef MAC_FEEDER_FLUSH_EN
    logic                flush_pend_reg, flush_pend_next;
`endif

    always_comb begin
        state_next    = state_reg;
        lane_cnt_next = lane_cnt_reg;
        grp_cnt_next  = grp_cnt_reg;
        acc_next      = acc_reg;
        lane_we       = '0;
        lane_zero     = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        last_issue    = (grp_cnt_reg == GRP_LAST);
`ifdef MAC_FEEDER_FLUSH_EN
        flush_pend_next = flush_pend_reg;
        if (flush_pend_reg) last_issue = 1'b1;
`endif
        case (state_reg)
            FILL: begin
                in_ready = 1'b1;
`ifdef MAC_FEEDER_FLUSH_EN
                // Flush wins over a pair offered in the same cycle, so refuse that pair.
                if (flush) begin
                    in_ready      = 1'b0;
                    grp_cnt_next  = '0;
                    lane_cnt_next = 2'd0;
                    if (lane_cnt_reg != 2'd0) begin
                        for (int i = 0; i < 4; i++) begin
                            if (2'(i) >= lane_cnt_reg) lane_we[i] = 1'b1;
                        end
                        lane_zero       = 1'b1;
                        flush_pend_next = 1'b1;
                        state_next      = ISSUE;
                    end else begin
                        state_next = OUT;
                    end
                end else
`endif
                if (bus.in_valid) begin
                    lane_we[lane_cnt_reg] = 1'b1;
                    lane_cnt_next         = lane_cnt_reg + 2'd1;
                    if (lane_cnt_reg == 2'd3) state_next = ISSUE;
                end
            end
            ISSUE: begin
                acc_next = bus.mac_out;
                if (last_issue) begin
                    grp_cnt_next = '0;
                    state_next   = OUT;
`ifdef MAC_FEEDER_FLUSH_EN
                    flush_pend_next = 1'b0;
`endif
                end else begin
                    grp_cnt_next = grp_cnt_reg + GW'(1);
                    state_next   = FILL;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    acc_next   = '0;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= FILL;
            lane_cnt_reg <= 2'd0;
            grp_cnt_reg  <= '0;
            acc_reg      <= '0;
`ifdef MAC_FEEDER_FLUSH_EN
            flush_pend_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            lane_cnt_reg <= lane_cnt_next;
            grp_cnt_reg  <= grp_cnt_next;
            acc_reg      <= acc_next;
`ifdef MAC_FEEDER_FLUSH_EN
            flush_pend_reg <= flush_pend_next;
`endif
        end
    end

    // Lanes keep their contents across issues; the next fill overwrites them.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [bw-1:0] a_reg;
        logic [bw-1:0] b_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                a_reg <= '0;
                b_reg <= '0;
            end else if (lane_we[gi]) begin
                a_reg <= lane_zero ? '0 : bus.in_a;
                b_reg <= lane_zero ? '0 : bus.in_b;
            end
        end

        assign mac_a[bw*gi +: bw] = a_reg;
        assign mac_b[bw*gi +: bw] = b_reg;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.mac_a     = mac_a;
    assign bus.mac_b     = mac_b;
    assign bus.mac_c     = acc_reg;
    assign bus.out_psum  = acc_reg;
    assign bus.busy      = (lane_cnt_reg != 2'd0) || (grp_cnt_reg != '0) || (state_reg != FILL);
endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: three instances (GROUPS=1, defaults, 8-bit psum) each
// closed around a behavioural 4-lane mac, driven one at a time through a selector.
module tb_mac_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         sel;
    logic       t_valid, t_ready;
    logic [3:0] t_a, t_b;
`ifdef MAC_FEEDER_FLUSH_EN
    logic       t_flush = 1'b0;
`endif
    int         cyc_ir_lo, cyc_ov;

    mac_feeder_if #(.bw(4), .psum_bw(16)) if_g1();
    mac_feeder_if #(.bw(4), .psum_bw(16)) if_g8();
    mac_feeder_if #(.bw(4), .psum_bw(8))  if_w8();

    // Behavioural mac: unsigned a lanes, signed b lanes, signed c.
    function automatic int mac_model(input logic [15:0] a, input logic [15:0] b, input int c);
        int s;
        logic [3:0] al;
        logic signed [3:0] bl;
        s = c;
        for (int i = 0; i < 4; i++) begin
            al = a[4*i +: 4];
            bl = b[4*i +: 4];
            s += int'(al) * int'(bl);
        end
        return s;
    endfunction

    assign if_g1.in_valid  = (sel == 0) && t_valid;
    assign if_g1.in_a      = t_a;
    assign if_g1.in_b      = t_b;
    assign if_g1.out_ready = (sel == 0) ? t_ready : 1'b1;
    assign if_g1.mac_out   = 16'(mac_model(if_g1.mac_a, if_g1.mac_b, int'($signed(if_g1.mac_c))));

    assign if_g8.in_valid  = (sel == 1) && t_valid;
    assign if_g8.in_a      = t_a;
    assign if_g8.in_b      = t_b;
    assign if_g8.out_ready = (sel == 1) ? t_ready : 1'b1;
    assign if_g8.mac_out   = 16'(mac_model(if_g8.mac_a, if_g8.mac_b, int'($signed(if_g8.mac_c))));

    assign if_w8.in_valid  = (sel == 2) && t_valid;
    assign if_w8.in_a      = t_a;
    assign if_w8.in_b      = t_b;
    assign if_w8.out_ready = (sel == 2) ? t_ready : 1'b1;
    assign if_w8.mac_out   = 8'(mac_model(if_w8.mac_a, if_w8.mac_b, int'($signed(if_w8.mac_c))));

    mac_feeder #(.bw(4), .psum_bw(16), .GROUPS(1)) dut_g1 (
        .clk(clk), .reset(reset),
`ifdef MAC_FEEDER_FLUSH_EN
        .flush(1'b0),
`endif
        .bus(if_g1.slave)
    );
    mac_feeder #(.bw(4), .psum_bw(16), .GROUPS(8)) dut_g8 (
        .clk(clk), .reset(reset),
`ifdef MAC_FEEDER_FLUSH_EN
        .flush(t_flush && (sel == 1)),
`endif
        .bus(if_g8.slave)
    );
    mac_feeder #(.bw(4), .psum_bw(8), .GROUPS(1)) dut_w8 (
        .clk(clk), .reset(reset),
`ifdef MAC_FEEDER_FLUSH_EN
        .flush(1'b0),
`endif
        .bus(if_w8.slave)
    );

    logic        o_in_ready, o_out_valid, o_busy;
    logic [15:0] o_mac_a, o_mac_b, o_mac_c, o_psum;

    always_comb begin
        o_in_ready  = if_g1.in_ready;
        o_out_valid = if_g1.out_valid;
        o_busy      = if_g1.busy;
        o_mac_a     = if_g1.mac_a;
        o_mac_b     = if_g1.mac_b;
        o_mac_c     = if_g1.mac_c;
        o_psum      = if_g1.out_psum;
        if (sel == 1) begin
            o_in_ready  = if_g8.in_ready;
            o_out_valid = if_g8.out_valid;
            o_busy      = if_g8.busy;
            o_mac_a     = if_g8.mac_a;
            o_mac_b     = if_g8.mac_b;
            o_mac_c     = if_g8.mac_c;
            o_psum      = if_g8.out_psum;
        end else if (sel == 2) begin
            o_in_ready  = if_w8.in_ready;
            o_out_valid = if_w8.out_valid;
            o_busy      = if_w8.busy;
            o_mac_a     = if_w8.mac_a;
            o_mac_b     = if_w8.mac_b;
            o_mac_c     = {8'h00, if_w8.mac_c};
            o_psum      = {8'h00, if_w8.out_psum};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (!o_in_ready) cyc_ir_lo++;
        if (o_out_valid) cyc_ov++;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        int w;
        w = 0;
        t_a = a;
        t_b = b;
        t_valid = 1'b1;
        while (!o_in_ready && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout in_ready=%b required 1 within 50 cycles", o_in_ready);
        end
        step();
        t_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output logic [15:0] psum);
        int w;
        w = 0;
        while (!o_out_valid && w < 50) begin
            step();
            w++;
        end
        n_cmp++;
        if (o_out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_wait_out out_valid=%b required 1 within 50 cycles", tag, o_out_valid);
        end
        psum = o_psum;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_cmp++;
            if ({o_mac_a, o_mac_b, o_mac_c, o_psum} !== 64'h0) begin
                n_bad++;
                $display("FAIL reset_data dut=%0d a=%h b=%h c=%h psum=%h required all 0",
                         s, o_mac_a, o_mac_b, o_mac_c, o_psum);
            end
            n_cmp++;
            if ({o_in_ready, o_out_valid, o_busy} !== 3'b100) begin
                n_bad++;
                $display("FAIL reset_ctrl dut=%0d in_ready,out_valid,busy=%b required 100",
                         s, {o_in_ready, o_out_valid, o_busy});
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single_group();
        sel = 0;
        t_ready = 1'b1;
        push(4'd1, 4'd1);
        push(4'd2, 4'hF);
        push(4'd3, 4'd2);
        push(4'd15, 4'h8);
        n_cmp++;
        if ({o_mac_a, o_mac_b} !== 32'hF321_82F1) begin
            n_bad++;
            $display("FAIL issue_lanes mac_a=%h mac_b=%h required F321 82F1", o_mac_a, o_mac_b);
        end
        n_cmp++;
        if ({o_in_ready, o_out_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL issue_ctrl in_ready,out_valid=%b required 00", {o_in_ready, o_out_valid});
        end
        step();
        n_cmp++;
        if (o_out_valid !== 1'b1 || o_psum !== 16'hFF8D) begin
            n_bad++;
            $display("FAIL single_result out_valid=%b psum=%h required 1 FF8D", o_out_valid, o_psum);
        end
        step();
        n_cmp++;
        if ({o_out_valid, o_in_ready} !== 2'b01 || o_psum !== 16'h0000) begin
            n_bad++;
            $display("FAIL single_after out_valid,in_ready=%b psum=%h required 01 0000",
                     {o_out_valid, o_in_ready}, o_psum);
        end
        $display("test_single_group done psum=FF8D expected");
    endtask

    task automatic test_full_accum();
        logic [15:0] psum;
        sel = 1;
        t_ready = 1'b1;
        #1;
        cyc_ir_lo = 0;
        cyc_ov = 0;
        for (int k = 0; k < 32; k++) begin
            repeat ($urandom_range(0, 2)) step();
            push(4'd15, 4'h8);
        end
        wait_out("full", psum);
        n_cmp++;
        if (psum !== 16'hF100) begin
            n_bad++;
            $display("FAIL full_psum psum=%h required F100", psum);
        end
        repeat (4) step();
        n_cmp++;
        if (cyc_ov !== 1) begin
            n_bad++;
            $display("FAIL full_result_count got=%0d required 1", cyc_ov);
        end
        n_cmp++;
        if (cyc_ir_lo !== 9) begin
            n_bad++;
            $display("FAIL full_in_ready_low_cycles got=%0d required 9", cyc_ir_lo);
        end
        $display("test_full_accum done psum=%h", psum);
    endtask

    task automatic test_wrap();
        logic [15:0] psum;
        sel = 2;
        t_ready = 1'b1;
        repeat (4) push(4'd15, 4'd7);
        wait_out("wrap", psum);
        n_cmp++;
        if (psum !== 16'h00A4) begin
            n_bad++;
            $display("FAIL wrap_psum psum=%h required 00A4", psum);
        end
        step();
        $display("test_wrap done psum=%h", psum);
    endtask

    task automatic test_backpressure();
        logic [15:0] psum;
        int held;
        sel = 0;
        t_ready = 1'b0;
        repeat (4) push(4'd2, 4'd1);
        wait_out("bp_first", psum);
        n_cmp++;
        if (psum !== 16'd8) begin
            n_bad++;
            $display("FAIL bp_first_psum psum=%h required 0008", psum);
        end
        t_valid = 1'b1;
        t_a = 4'd9;
        t_b = 4'd7;
        held = 0;
        repeat (10) begin
            step();
            if (o_out_valid === 1'b1 && o_psum === 16'd8 && o_in_ready === 1'b0) held++;
        end
        n_cmp++;
        if (held !== 10) begin
            n_bad++;
            $display("FAIL bp_hold stable_cycles=%0d required 10", held);
        end
        t_valid = 1'b0;
        t_ready = 1'b1;
        step();
        n_cmp++;
        if ({o_out_valid, o_in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_release out_valid,in_ready=%b required 01", {o_out_valid, o_in_ready});
        end
        repeat (4) push(4'd1, 4'd1);
        wait_out("bp_second", psum);
        n_cmp++;
        if (psum !== 16'd4) begin
            n_bad++;
            $display("FAIL bp_second_psum psum=%h required 0004", psum);
        end
        step();
        $display("test_backpressure done psum=%h", psum);
    endtask

    task automatic test_reset_midfill();
        logic [15:0] psum;
        sel = 0;
        t_ready = 1'b1;
        push(4'd7, 4'd7);
        push(4'd7, 4'd7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({o_busy, o_in_ready} !== 2'b01 || o_mac_a !== 16'h0000) begin
            n_bad++;
            $display("FAIL midfill_reset busy,in_ready=%b mac_a=%h required 01 0000",
                     {o_busy, o_in_ready}, o_mac_a);
        end
        repeat (4) push(4'd2, 4'd3);
        wait_out("midfill", psum);
        n_cmp++;
        if (psum !== 16'd24) begin
            n_bad++;
            $display("FAIL midfill_psum psum=%h required 0018", psum);
        end
        step();
        $display("test_reset_midfill done psum=%h", psum);
    endtask

`ifdef MAC_FEEDER_FLUSH_EN
    task automatic test_flush();
        sel = 1;
        t_ready = 1'b1;
        push(4'd3, 4'd3);
        push(4'd2, 4'hC);
        t_flush = 1'b1;
        step();
        t_flush = 1'b0;
        n_cmp++;
        if ({o_mac_a, o_mac_b} !== 32'h0023_00C3 || o_in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_issue mac_a=%h mac_b=%h in_ready=%b required 0023 00C3 0",
                     o_mac_a, o_mac_b, o_in_ready);
        end
        step();
        n_cmp++;
        if (o_out_valid !== 1'b1 || o_psum !== 16'd1) begin
            n_bad++;
            $display("FAIL flush_psum out_valid=%b psum=%h required 1 0001", o_out_valid, o_psum);
        end
        step();
        t_flush = 1'b1;
        step();
        t_flush = 1'b0;
        n_cmp++;
        if (o_out_valid !== 1'b1 || o_psum !== 16'd0) begin
            n_bad++;
            $display("FAIL flush_empty out_valid=%b psum=%h required 1 0000", o_out_valid, o_psum);
        end
        step();
        $display("test_flush done");
    endtask
`endif

    initial begin
        reset = 1'b1;
        sel = 0;
        t_valid = 1'b0;
        t_ready = 1'b1;
        t_a = '0;
        t_b = '0;
        cyc_ir_lo = 0;
        cyc_ov = 0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_single_group();
        test_full_accum();
        test_wrap();
        test_backpressure();
        test_reset_midfill();
`ifdef MAC_FEEDER_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
